hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipeline.
- Consumes the register specifiers and control bits held in the D, E, M and W pipeline registers.
- Produces the stall, flush and forward selects those registers and the bypass muxes obey.
- Adds a sequential occupancy tracker for multi-cycle mul/div ops resident in EX.

Parameters:
- MD_LAT, 4: total cycles a mul/div op occupies EX; legal range 1..16.
- CNT_W, 4: width of the occupancy counter; must hold MD_LAT-2.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- RsD, RtD  input  5 each  source specifiers in D
- RsE, RtE  input  5 each  source specifiers in E
- WriteRegE, WriteRegM, WriteRegW  input  5 each  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  input  1 each  write enable per stage
- MemtoRegE, MemtoRegM  input  1 each  load in E / M
- BranchD  input  1  branch in D
- PCSrcD  input  1  branch taken (resolved in D)
- MulDivE  input  1  multi-cycle op in E
- StallF, StallD, StallE  output  1 each  hold the PC, D register and E register
- FlushD, FlushE, FlushM  output  1 each  bubble the D, E and M registers
- ForwardAE, ForwardBE  output  2 each  E operand select: 00 = regfile, 01 = W result, 10 = M result
- ForwardAD, ForwardBD  output  1 each  D branch compare takes the M result
- MdBusy  output  1  multi-cycle op holding EX
- MdDone  output  1  last EX cycle of the multi-cycle op

Behaviour:
- Register r0 never matches in any comparison: a specifier equal to 0 yields no stall and no forward.
- ForwardAE:
  - 10 if RegWriteM and WriteRegM==RsE.
  - Else 01 if RegWriteW and WriteRegW==RsE.
  - Else 00. M has priority over W.
  - ForwardBE is identical, using RtE.
- ForwardAD = RegWriteM & (WriteRegM==RsD). ForwardBD is the same using RtD.
- lwstall = MemtoRegE & (WriteRegE==RsD | WriteRegE==RtD).
- brstall = BranchD & ((RegWriteE & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM∈{RsD,RtD})).
- FSM states: IDLE, BUSY. Registered counter cnt[CNT_W-1:0].
- Reset (asynchronous): state=IDLE, cnt=0. Outputs are combinational from state and inputs. With all inputs at 0, every output is 0.
- IDLE, MulDivE=1, MD_LAT>1:
  - This cycle: md_stall=1.
  - Next state BUSY, cnt=MD_LAT-2.
- IDLE, MulDivE=1, MD_LAT==1: no stall, MdDone=1 this cycle, stay IDLE.
- BUSY, cnt!=0: md_stall=1, cnt decrements.
- BUSY, cnt==0: md_stall=0, MdDone=1, next state IDLE. MulDivE is ignored this cycle; the op leaves E at this edge, so no retrigger.
- Total EX occupancy is exactly MD_LAT cycles.
- MdBusy = md_stall.
- md_stall=1 dominates:
  - StallF=StallD=StallE=1 and FlushM=1.
  - FlushE=0 and FlushD=0.
  - lwstall and brstall are suppressed.
- md_stall=0:
  - StallF=StallD=FlushE=lwstall|brstall.
  - StallE=0, FlushM=0.
  - FlushD=PCSrcD & ~StallD. A taken branch waiting on an operand is not flushed until it resolves.
- Back-to-back mul/div: the op entering E on the MdDone edge is seen in IDLE the next cycle and starts a new sequence.
- rst asserted mid-BUSY: returns to IDLE immediately; stalls drop in the same cycle.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds outputs StallCnt[31:0] and FlushCnt[31:0]. Both reset to 0 and wrap at 2^32.
  - StallCnt increments each cycle StallF=1.
  - FlushCnt increments each cycle FlushD|FlushE=1.
- Undefined: ports and logic are absent, and the port list is otherwise identical.

Test Plan:
- Forwarding priority:
  - RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5, RsE=5 -> ForwardAE=10.
  - Then RegWriteM=0 -> ForwardAE=01.
  - RsE=0 with WriteRegM=0 -> ForwardAE=00.
- Load-use: MemtoRegE=1, WriteRegE=8, RtD=8 -> StallF=StallD=FlushE=1 for one cycle; all 0 when MemtoRegE drops.
- Branch hazards:
  - BranchD=1, RegWriteE=1, WriteRegE=3, RsD=3, PCSrcD=1 -> StallD=1, FlushD=0.
  - Next cycle with no hazard -> FlushD=1.
- MD_LAT=4, MulDivE held high:
  - Stalls StallF=StallD=StallE=FlushM=1 on cycles 0,1,2.
  - Cycle 3: stalls low, MdDone=1.
  - Cycle 4 with MulDivE=0: IDLE, no stall.
- Reset mid-operation: MD_LAT=4, assert rst during cycle 1 of BUSY -> MdBusy and all stalls 0 immediately; after release with MulDivE=0 the FSM stays IDLE.
- With HAZARD_PERF_EN: the MD_LAT=4 sequence plus one load-use stall -> StallCnt=4, FlushCnt=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard, forwarding and mul/div occupancy control for the 5-stage pipeline
//
// Purpose:
//   Looks at the register specifiers and control bits held in the D, E, M and
//   W pipeline registers and produces the stall, flush and bypass selects the
//   pipeline obeys. A small IDLE/BUSY FSM tracks a multi-cycle mul/div op that
//   sits in EX for MD_LAT cycles and freezes the front of the pipe meanwhile.
//
// Parameters:
//   MD_LAT  total EX cycles of a mul/div op (1..16)
//   CNT_W   occupancy counter width, must hold MD_LAT-2
//
// Ports:
//   clk, rst                         clock (rising edge), async active-high reset
//   RsD, RtD                         source specifiers in D
//   RsE, RtE                         source specifiers in E
//   WriteRegE/M/W, RegWriteE/M/W     destination and write enable per stage
//   MemtoRegE, MemtoRegM             load in E / M
//   BranchD, PCSrcD                  branch in D / branch taken
//   MulDivE                          multi-cycle op in E
//   StallF, StallD, StallE           hold PC, D register, E register
//   FlushD, FlushE, FlushM           bubble D, E, M registers
//   ForwardAE, ForwardBE             E operand select: 00 regfile, 01 W, 10 M
//   ForwardAD, ForwardBD             D branch compare takes the M result
//   MdBusy, MdDone                   mul/div holding EX / last EX cycle
//   StallCnt, FlushCnt               stall / flush cycle counters, present only
//                                    when HAZARD_PERF_EN is defined

module hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       PCSrcD,
  input  logic       MulDivE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       MdBusy,
`ifdef HAZARD_PERF_EN
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt,
`endif
  output logic       MdDone
);

  // Value loaded into the counter when an op enters BUSY; the entry cycle in
  // IDLE and the final cnt==0 cycle account for the remaining two EX cycles.
  localparam int              CNT_INIT_I = (MD_LAT > 1) ? (MD_LAT - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(CNT_INIT_I);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic md_stall;
  logic md_done;
  logic lwstall;
  logic brstall;
  logic hz_stall;

  // r0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  // M is the younger producer, so it wins over W.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && reg_match(RsE, WriteRegM)) begin
      ForwardAE = 2'b10;
    end else if (RegWriteW && reg_match(RsE, WriteRegW)) begin
      ForwardAE = 2'b01;
    end
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && reg_match(RtE, WriteRegM)) begin
      ForwardBE = 2'b10;
    end else if (RegWriteW && reg_match(RtE, WriteRegW)) begin
      ForwardBE = 2'b01;
    end
  end

  assign ForwardAD = RegWriteM & reg_match(RsD, WriteRegM);
  assign ForwardBD = RegWriteM & reg_match(RtD, WriteRegM);

  // ---------------------------------------------------------------------------
  // Data hazards
  // ---------------------------------------------------------------------------
  // Load in E whose result D needs next cycle: cannot be forwarded in time.
  assign lwstall = MemtoRegE & (reg_match(RsD, WriteRegE) | reg_match(RtD, WriteRegE));

  // Branches compare in D, so an ALU result still in E, or a load result still
  // in M, is not yet available to the comparator.
  assign brstall = BranchD &
                   ((RegWriteE & (reg_match(RsD, WriteRegE) | reg_match(RtD, WriteRegE))) |
                    (MemtoRegM & (reg_match(RsD, WriteRegM) | reg_match(RtD, WriteRegM))));

  assign hz_stall = lwstall | brstall;

  // ---------------------------------------------------------------------------
  // Mul/div occupancy FSM
  // ---------------------------------------------------------------------------
  // Outputs are decoded from the current state and inputs. They are gated by
  // rst so the stalls release in the very cycle reset is raised, even while
  // MulDivE is still high from the aborted op.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    md_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MulDivE) begin
          if (MD_LAT > 1) begin
            md_stall = 1'b1;
            state_d  = BUSY;
            cnt_d    = CNT_INIT;
          end else begin
            md_done = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          md_stall = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
        end else begin
          // The op leaves E at this edge; MulDivE seen now belongs to it,
          // so it must not retrigger. A following op is picked up in IDLE.
          md_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (rst) begin
      md_stall = 1'b0;
      md_done  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall / flush resolution
  // ---------------------------------------------------------------------------
  // While mul/div holds EX the whole front freezes and a bubble goes into M;
  // ordinary hazards are masked since nothing in D or E moves anyway.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (md_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else begin
      StallF = hz_stall;
      StallD = hz_stall;
      FlushE = hz_stall;
      // A taken branch still waiting on an operand holds in D; the redirect
      // flush happens only once it actually resolves.
      FlushD = PCSrcD & ~hz_stall;
    end
  end

  assign MdBusy = md_stall;
  assign MdDone = md_done;

`ifdef HAZARD_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32)
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (FlushD | FlushE) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
`ifdef HAZARD_PERF_EN
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
`ifdef HAZARD_PERF_EN
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard testbench for hazard_ctrl

module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM;
  logic       BranchD, PCSrcD, MulDivE;
  logic       StallF, StallD, StallE;
  logic       FlushD, FlushE, FlushM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD;
  logic       MdBusy, MdDone;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [13:0] exp_q[$];
  logic [13:0] obs;

  hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .RsD       (RsD),
    .RtD       (RtD),
    .RsE       (RsE),
    .RtE       (RtE),
    .WriteRegE (WriteRegE),
    .WriteRegM (WriteRegM),
    .WriteRegW (WriteRegW),
    .RegWriteE (RegWriteE),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .MemtoRegE (MemtoRegE),
    .MemtoRegM (MemtoRegM),
    .BranchD   (BranchD),
    .PCSrcD    (PCSrcD),
    .MulDivE   (MulDivE),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .FlushM    (FlushM),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .ForwardAD (ForwardAD),
    .ForwardBD (ForwardBD),
    .MdBusy    (MdBusy),
`ifdef HAZARD_PERF_EN
    .StallCnt  (StallCnt),
    .FlushCnt  (FlushCnt),
`endif
    .MdDone    (MdDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {StallF, StallD, StallE, FlushD, FlushE, FlushM,
                ForwardAE, ForwardBE, ForwardAD, ForwardBD, MdBusy, MdDone};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] ev(input logic sf, input logic sd, input logic se,
                                     input logic fd, input logic fe, input logic fm,
                                     input logic [1:0] fae, input logic [1:0] fbe,
                                     input logic fad, input logic fbd,
                                     input logic busy, input logic done);
    return {sf, sd, se, fd, fe, fm, fae, fbe, fad, fbd, busy, done};
  endfunction

  // Inputs are applied at a falling edge; the expectation is queued, the
  // combinational outputs are sampled 2 time units later, well before the
  // next rising edge, and the run then moves to the next falling edge.
  task automatic step(input string tag, input logic [13:0] e);
    logic [13:0] x;
    exp_q.push_back(e);
    #2;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      chk(tag, {18'd0, obs}, {18'd0, x});
    end
    @(negedge clk);
  endtask

  task automatic clear_in();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; PCSrcD = 0; MulDivE = 0;
  endtask

  localparam logic [13:0] ZERO = 14'd0;
  localparam logic [13:0] LW   = 14'b110010_00_00_0_0_0_0;
  localparam logic [13:0] MDS  = 14'b111001_00_00_0_0_1_0;
  localparam logic [13:0] MDD  = 14'b000000_00_00_0_0_0_1;

  initial begin
    rst = 1'b1;
    clear_in();
    @(negedge clk);
    step("reset_zero", ZERO);
    rst = 1'b0;
    step("idle_zero", ZERO);

    // Forwarding priority
    RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5; RsE = 5;
    step("fwd_m_over_w", ev(0,0,0,0,0,0, 2'b10, 2'b00, 0,0,0,0));
    RegWriteM = 0;
    step("fwd_w", ev(0,0,0,0,0,0, 2'b01, 2'b00, 0,0,0,0));
    RegWriteM = 1; WriteRegM = 0; RsE = 0; WriteRegW = 7; RtE = 7;
    step("fwd_r0_and_b_w", ev(0,0,0,0,0,0, 2'b00, 2'b01, 0,0,0,0));
    clear_in();
    RegWriteM = 1; WriteRegM = 9; RsD = 9; RtD = 9;
    step("fwd_d_both", ev(0,0,0,0,0,0, 2'b00, 2'b00, 1,1,0,0));

    // Load-use
    clear_in();
    MemtoRegE = 1; WriteRegE = 8; RtD = 8;
    step("lw_stall", LW);
    MemtoRegE = 0;
    step("lw_release", ZERO);
    MemtoRegE = 1; WriteRegE = 0; RtD = 0;
    step("lw_r0_none", ZERO);

    // Branch hazards
    clear_in();
    BranchD = 1; RegWriteE = 1; WriteRegE = 3; RsD = 3; PCSrcD = 1;
    step("br_stall_e", LW);
    RegWriteE = 0;
    step("br_resolve_flush", ev(0,0,0,1,0,0, 2'b00, 2'b00, 0,0,0,0));
    clear_in();
    BranchD = 1; MemtoRegM = 1; WriteRegM = 4; RtD = 4;
    step("br_stall_load_m", LW);

    // Mul/div, MD_LAT=4; a load-use during BUSY must stay masked
    clear_in();
    MulDivE = 1;
    step("md_c0", MDS);
    MemtoRegE = 1; WriteRegE = 8; RtD = 8;
    step("md_c1_lw_masked", MDS);
    MemtoRegE = 0; WriteRegE = 0; RtD = 0;
    step("md_c2", MDS);
    step("md_c3_done", MDD);
    MulDivE = 0;
    step("md_c4_idle", ZERO);

    // Back-to-back ops, then reset in BUSY cycle 1 of the second op
    MulDivE = 1;
    step("b2b_c0", MDS);
    step("b2b_c1", MDS);
    step("b2b_c2", MDS);
    step("b2b_c3_done", MDD);
    step("b2b_retrigger", MDS);
    rst = 1'b1;
    step("rst_mid_busy", ZERO);
    rst = 1'b0; MulDivE = 0;
    step("post_rst_idle0", ZERO);
    step("post_rst_idle1", ZERO);

`ifdef HAZARD_PERF_EN
    rst = 1'b1;
    step("perf_rst", ZERO);
    rst = 1'b0;
    MulDivE = 1;
    step("perf_md0", MDS);
    step("perf_md1", MDS);
    step("perf_md2", MDS);
    step("perf_md3", MDD);
    MulDivE = 0; MemtoRegE = 1; WriteRegE = 8; RtD = 8;
    step("perf_lw", LW);
    clear_in();
    #2;
    chk("stall_cnt", StallCnt, 32'd4);
    chk("flush_cnt", FlushCnt, 32'd1);
`endif

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
